// File: rtl/conv_scan_ctrl.sv
// Raster-order window sequencer for the 3x3 convolution datapath.
// Issues column shifts and row advances, and presents each complete window with its output coordinate.
module conv_scan_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [1:0] stride_i,
    input  logic       out_ready_i,
    output logic       busy_o,
    output logic       shift_buffer_o,
    output logic       window_en_o,
    output logic       row_shift_o,
    output logic       win_valid_o,
    output logic [7:0] out_row_o,
    output logic [7:0] out_col_o,
    output logic       done_o
);

    // state   | meaning
    // IDLE    | waiting for start
    // PRIME   | three column shifts fill a fresh window
    // EMIT    | window presented, waiting for out_ready
    // SLIDE   | stride column shifts to the next window
    // ROW_ADV | stride line-buffer row advances
    // DONE    | one-cycle frame-finished pulse
    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_EMIT, S_SLIDE, S_ROW_ADV, S_DONE
    } state_t;

    localparam logic [7:0] OUT_H1 = 8'((IMG_H - 3) / 1 + 1);
    localparam logic [7:0] OUT_H2 = 8'((IMG_H - 3) / 2 + 1);
    localparam logic [7:0] OUT_H3 = 8'((IMG_H - 3) / 3 + 1);
    localparam logic [8:0] IMG_W9 = 9'(IMG_W);

    state_t     state_q, state_d;
    logic [1:0] stride_q, stride_d;
    logic [1:0] step_q, step_d;
    logic [7:0] col_cnt_q, col_cnt_d;
    logic [7:0] out_row_q, out_row_d;
    logic [7:0] out_col_q, out_col_d;

    logic [7:0] out_h;
    logic       fits_col;
    logic       more_rows;
    logic       last_step;

    always_comb begin
        case (stride_q)
            2'd2:    out_h = OUT_H2;
            2'd3:    out_h = OUT_H3;
            default: out_h = OUT_H1;
        endcase
    end

    // Compares done one bit wider than the counters so they never wrap.
    assign fits_col  = ({1'b0, col_cnt_q} + {7'b0, stride_q}) <= IMG_W9;
    assign more_rows = ({1'b0, out_row_q} + 9'd1) < {1'b0, out_h};
    assign last_step = (step_q == (stride_q - 2'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            stride_q  <= 2'd0;
            step_q    <= 2'd0;
            col_cnt_q <= 8'd0;
            out_row_q <= 8'd0;
            out_col_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            stride_q  <= stride_d;
            step_q    <= step_d;
            col_cnt_q <= col_cnt_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stride_d  = stride_q;
        step_d    = step_q;
        col_cnt_d = col_cnt_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    stride_d  = (stride_i == 2'd0) ? 2'd1 : stride_i;
                    step_d    = 2'd0;
                    col_cnt_d = 8'd0;
                    out_row_d = 8'd0;
                    out_col_d = 8'd0;
                    state_d   = S_PRIME;
                end
            end
            S_PRIME: begin
                col_cnt_d = col_cnt_q + 8'd1;
                if (col_cnt_q == 8'd2) state_d = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready_i) begin
                    step_d = 2'd0;
                    if (fits_col) begin
                        out_col_d = out_col_q + 8'd1;
                        state_d   = S_SLIDE;
                    end else if (more_rows) begin
                        state_d = S_ROW_ADV;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SLIDE: begin
                col_cnt_d = col_cnt_q + 8'd1;
                step_d    = step_q + 2'd1;
                if (last_step) state_d = S_EMIT;
            end
            S_ROW_ADV: begin
                step_d = step_q + 2'd1;
                if (last_step) begin
                    out_row_d = out_row_q + 8'd1;
                    out_col_d = 8'd0;
                    col_cnt_d = 8'd0;
                    state_d   = S_PRIME;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o         = (state_q != S_IDLE);
        shift_buffer_o = (state_q == S_PRIME) || (state_q == S_SLIDE);
        window_en_o    = shift_buffer_o;
        row_shift_o    = (state_q == S_ROW_ADV);
        win_valid_o    = (state_q == S_EMIT);
        done_o         = (state_q == S_DONE);
        out_row_o      = out_row_q;
        out_col_o      = out_col_q;
    end

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Randomized bench for conv_scan_ctrl: two frame geometries, scoreboard of expected windows.
module tb_conv_scan_ctrl;

    localparam int NI = 2;
    int IW[NI] = '{5, 7};
    int IH[NI] = '{5, 6};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] stride = 2'd0;
    logic       ready = 1'b1;
    logic       start[NI];
    logic       busy[NI], sb[NI], we[NI], rs[NI], wv[NI], dn[NI];
    logic [7:0] orow[NI], ocol[NI];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    conv_scan_ctrl #(.IMG_W(5), .IMG_H(5)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .stride_i(stride),
        .out_ready_i(ready), .busy_o(busy[0]), .shift_buffer_o(sb[0]),
        .window_en_o(we[0]), .row_shift_o(rs[0]), .win_valid_o(wv[0]),
        .out_row_o(orow[0]), .out_col_o(ocol[0]), .done_o(dn[0])
    );

    conv_scan_ctrl #(.IMG_W(7), .IMG_H(6)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .stride_i(stride),
        .out_ready_i(ready), .busy_o(busy[1]), .shift_buffer_o(sb[1]),
        .window_en_o(we[1]), .row_shift_o(rs[1]), .win_valid_o(wv[1]),
        .out_row_o(orow[1]), .out_col_o(ocol[1]), .done_o(dn[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input int d, input string tag);
        chk({tag, "_busy"}, busy[d], 0);
        chk({tag, "_shift"}, sb[d], 0);
        chk({tag, "_wen"}, we[d], 0);
        chk({tag, "_rowsh"}, rs[d], 0);
        chk({tag, "_valid"}, wv[d], 0);
        chk({tag, "_row"}, orow[d], 0);
        chk({tag, "_col"}, ocol[d], 0);
        chk({tag, "_done"}, dn[d], 0);
    endtask

    // One frame on instance d. stall_r/stall_c select a window held off for 4 cycles;
    // abort_win>0 pulses reset in the first slide after that many windows.
    task automatic run_frame(input int d, input int s_in, input int rdy_pct,
                             input bit busy_starts, input int stall_r, input int stall_c,
                             input int abort_win, input int fixed_done);
        int s, ow, oh, cyc, stalls, held, n_win, shifts_since, total_sh, total_rs, exp_done;
        bit finished, prev_wv;
        int exp_r[$];
        int exp_c[$];
        s  = (s_in == 0) ? 1 : s_in;
        ow = (IW[d] - 3) / s + 1;
        oh = (IH[d] - 3) / s + 1;
        for (int r = 0; r < oh; r++)
            for (int c = 0; c < ow; c++) begin
                exp_r.push_back(r);
                exp_c.push_back(c);
            end
        stalls = 0; held = 0; n_win = 0; shifts_since = 0; total_sh = 0; total_rs = 0;
        finished = 0; prev_wv = 0;

        @(posedge clk); #1;
        stride = 2'(s_in);
        ready = 1'b1;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        cyc = 1;
        while (!finished && cyc < 3000) begin
            stride = 2'($urandom_range(3));
            if (wv[d] && int'(orow[d]) == stall_r && int'(ocol[d]) == stall_c && held < 4) begin
                ready = 1'b0;
                held++;
            end else begin
                ready = ($urandom_range(99) < rdy_pct);
            end
            if (busy_starts) start[d] = ($urandom_range(3) == 0);
            @(negedge clk);
            chk("wen_eq_shift", we[d], sb[d]);
            chk("busy_in_frame", busy[d], 1);
            if (wv[d]) begin
                if (exp_r.size() == 0) begin
                    chk("extra_window", 1, 0);
                end else begin
                    chk("out_row", orow[d], exp_r[0]);
                    chk("out_col", ocol[d], exp_c[0]);
                    if (!prev_wv) begin
                        chk("shifts_before_win", shifts_since, (exp_c[0] == 0) ? 3 : s);
                        if (n_win == 0) chk("first_valid_cycle", cyc, 4);
                        n_win++;
                        shifts_since = 0;
                    end
                end
                chk("no_shift_in_emit", sb[d] | rs[d], 0);
                chk("done_vs_valid", dn[d], 0);
                if (ready) begin
                    if (exp_r.size() != 0) begin
                        void'(exp_r.pop_front());
                        void'(exp_c.pop_front());
                    end
                end else begin
                    stalls++;
                end
            end
            if (sb[d]) begin
                shifts_since++;
                total_sh++;
            end
            if (rs[d]) total_rs++;
            if (abort_win > 0 && n_win >= abort_win && sb[d] && !wv[d]) begin
                #1 rst_n = 1'b0;
                #1 chk_all_zero(d, "reset_mid");
                start[d] = 1'b0;
                #1 rst_n = 1'b1;
                repeat (2) @(negedge clk);
                chk("idle_after_reset", busy[d], 0);
                return;
            end
            if (dn[d]) begin
                exp_done = 1 + oh * (4 + (ow - 1) * (s + 1)) + (oh - 1) * s + stalls;
                chk("done_cycle", cyc, exp_done);
                if (fixed_done > 0) chk("done_cycle_abs", cyc, fixed_done);
                chk("windows_left", exp_r.size(), 0);
                chk("shift_total", total_sh, oh * (3 + (ow - 1) * s));
                chk("row_shift_total", total_rs, (oh - 1) * s);
                finished = 1;
            end
            prev_wv = wv[d];
            @(posedge clk); #1;
            cyc++;
        end
        start[d] = 1'b0;
        if (!finished) begin
            chk("frame_timeout", 0, 1);
        end else begin
            @(negedge clk);
            chk("busy_after_done", busy[d], 0);
            chk("done_one_cycle", dn[d], 0);
        end
    endtask

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero(0, "reset0");
        chk_all_zero(1, "reset1");
        @(posedge clk); #1 rst_n = 1'b1;

        run_frame(0, 1, 100, 0, -1, -1, 0, 27);
        run_frame(0, 0, 100, 0, -1, -1, 0, 27);
        run_frame(0, 1, 100, 0, 1, 1, 0, 31);
        run_frame(1, 2, 100, 0, -1, -1, 0, 0);
        run_frame(1, 3, 100, 0, -1, -1, 0, 0);
        run_frame(1, 1, 100, 1, -1, -1, 2, 0);
        run_frame(1, 3, 100, 1, -1, -1, 0, 0);
        run_frame(0, 2, 100, 1, -1, -1, 0, 0);
        for (int k = 0; k < 10; k++)
            run_frame(int'($urandom_range(1)), int'($urandom_range(3)),
                      int'($urandom_range(100, 40)), 1'b1, -1, -1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
